uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the uart block. It monitors the uart's `received` flag and `data_received` byte. Each rising edge of `received` pushes exactly one byte into a FIFO in the system clock domain. Consumers (display/command logic) pop bytes through a first-word-fall-through read port with empty/full/count status and a sticky overflow flag.

---
 rtl/uart_rx_fifo.sv | 97 +++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the uart: synchronises the uart's received flag,
// turns each rising edge into one push, and presents a first-word-fall-through read port.
module uart_rx_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              received,
   input  logic [7:0]        data_received,
   input  logic              rd_en,
   output logic [7:0]        dout,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   logic [7:0]        mem [DEPTH];
   logic              s1_q, s2_q, s3_q;
   logic              seen_q, arm_q;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              push, do_wr, do_rd;

   // arm_q blocks a spurious push when received is already high as reset releases:
   // it sets only once a genuine low sample of received has been captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         seen_q <= 1'b0;
         arm_q  <= 1'b0;
      end else begin
         s1_q   <= received;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         seen_q <= 1'b1;
         arm_q  <= arm_q | (seen_q & ~s1_q);
      end
   end

   assign push  = s2_q & ~s3_q & arm_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_CNT);
   assign do_rd = rd_en & ~empty;
   assign do_wr = push & (~full | do_rd);

   always_comb begin
      wr_ptr_d   = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
         count_d = count_q - 1'b1;
      end
      overflow_d = overflow_q;
      if (push && !do_wr) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; stale contents are masked by empty.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q] <= data_received;
      end
   end

   assign dout     = empty ? 8'h00 : mem[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives received/data_received pulses and pops,
// comparing status and FWFT data against hand-computed values.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       received = 1'b0;
   logic [7:0] data_received = 8'h00;
   logic       rd_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] dout;
   logic       empty, full, overflow;
   logic [4:0] count;

   int n_checks = 0;
   int n_pass = 0;

   uart_rx_fifo #(.ADDR_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .received      (received),
      .data_received (data_received),
      .rd_en         (rd_en),
      .dout          (dout),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .overflow      (overflow),
      .ovf_clr       (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_received = b;
      received = 1'b1;
      repeat (4) tick();
      received = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_b;

      repeat (3) tick();
      reset = 1'b0;
      repeat (3) tick();

      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_dout", dout, 8'h00);
      check("rst_ovf", overflow, 0);
      rd_en = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      check("underrun_count", count, 0);
      check("underrun_empty", empty, 1);
      check("underrun_dout", dout, 8'h00);

      // Single byte, received held high for 50 cycles
      data_received = 8'hA5;
      received = 1'b1;
      tick();
      check("lat_e0_empty", empty, 1);
      tick();
      check("lat_e1_empty", empty, 1);
      tick();
      check("lat_e2_empty", empty, 0);
      check("lat_e2_dout", dout, 8'hA5);
      repeat (47) tick();
      check("held_count", count, 1);
      received = 1'b0;
      repeat (4) tick();
      check("single_dout", dout, 8'hA5);
      pop();
      check("single_pop_empty", empty, 1);
      check("single_pop_count", count, 0);

      // Ordering across pointer wrap
      for (int r = 0; r < 4; r++) begin
         for (int i = 1; i <= 5; i++) send_byte(8'(i));
         check($sformatf("order%0d_count", r), count, 5);
         for (int i = 1; i <= 5; i++) begin
            check($sformatf("order%0d_b%0d", r, i), dout, 8'(i));
            pop();
         end
         check($sformatf("order%0d_empty", r), empty, 1);
      end

      // Fill and overflow
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      check("fill_ovf", overflow, 0);
      send_byte(8'h20);
      check("drop_ovf", overflow, 1);
      check("drop_count", count, 16);
      check("drop_head", dout, 8'h10);
      pop();
      check("pop1_count", count, 15);
      check("pop1_full", full, 0);
      check("ovf_sticky", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", overflow, 0);

      // Push and pop in the same cycle while full
      send_byte(8'h21);
      check("refill_full", full, 1);
      data_received = 8'h77;
      received = 1'b1;
      tick();
      tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("simul_count", count, 16);
      check("simul_ovf", overflow, 0);
      tick();
      received = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 16; i++) begin
         exp_b = (i < 14) ? 8'h12 + 8'(i) : ((i == 14) ? 8'h21 : 8'h77);
         check($sformatf("drain_%0d", i), dout, exp_b);
         pop();
      end
      check("drain_empty", empty, 1);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i));
      check("pre_rst_count", count, 7);
      data_received = 8'h99;
      received = 1'b1;
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_full", full, 0);
      check("arst_dout", dout, 8'h00);
      check("arst_ovf", overflow, 0);
      tick();
      tick();
      reset = 1'b0;
      repeat (10) tick();
      check("post_rst_held_count", count, 0);
      check("post_rst_held_empty", empty, 1);
      received = 1'b0;
      repeat (4) tick();
      data_received = 8'h3C;
      received = 1'b1;
      repeat (3) tick();
      check("rearm_empty", empty, 0);
      check("rearm_dout", dout, 8'h3C);
      check("rearm_count", count, 1);
      received = 1'b0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
